// File: rtl/ms_cfg_ctrl_pkg.sv
// Shared types and constants for the config word assembler.
// Bundles the FIFO word type, status bit positions and reset values.
package ms_cfg_ctrl_pkg;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } cfg_word_t;

  typedef enum logic {
    S_LO,
    S_HI
  } asm_state_t;

  localparam int STS_OVF    = 7;
  localparam int STS_SELERR = 6;
  localparam int STS_BUSY   = 5;

  localparam logic [3:0]  rst_config_addr  = '0;
  localparam logic [15:0] rst_config_data  = '0;
  localparam logic [7:0]  rst_sl_send_data = '0;

endpackage

// File: rtl/ms_cfg_word_assembler_if.sv
// Master byte bus, status return and target word handshake.
// The DUT side uses the slave modport.
interface ms_cfg_word_assembler_if;
  logic [7:0]  ma_send_data;
  logic [3:0]  ma_sel;
  logic        ma_enable;
  logic        clr_status;
  logic        config_ready;
  logic        config_valid;
  logic [3:0]  config_addr;
  logic [15:0] config_data;
  logic [7:0]  sl_send_data;

  modport master (
    output ma_send_data,
    output ma_sel,
    output ma_enable,
    output clr_status,
    output config_ready,
    input  config_valid,
    input  config_addr,
    input  config_data,
    input  sl_send_data
  );

  modport slave (
    input  ma_send_data,
    input  ma_sel,
    input  ma_enable,
    input  clr_status,
    input  config_ready,
    output config_valid,
    output config_addr,
    output config_data,
    output sl_send_data
  );
endinterface

// File: rtl/ms_cfg_word_fifo.sv
// Word FIFO for assembled config words.
// Pointers carry an extra MSB to tell full from empty.
module ms_cfg_word_fifo
  import ms_cfg_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  cfg_word_t din,
  output cfg_word_t head,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  cfg_word_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Memory is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{addr: rst_config_addr,
                    data: rst_config_data};
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ms_cfg_word_assembler.sv
// Pairs master bytes into 16-bit config words and buffers them.
// Optional err_cnt output is enabled by MS_CFG_ERR_CNT_EN.
module ms_cfg_word_assembler
  import ms_cfg_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  ms_cfg_word_assembler_if.slave bus
`ifdef MS_CFG_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  asm_state_t  state;
  logic [7:0]  lo_q;
  logic [3:0]  sel_q;
  logic        ovf;
  logic        sel_err;
  logic [7:0]  sts_q;

  cfg_word_t   head;
  logic        full;
  logic        empty;
  logic [AW:0] count;

  logic        lo_take;
  logic        hi_hit;
  logic        sel_miss;
  logic        pop;
  logic        push;
  logic        drop;
  logic        ovf_d;
  logic        sel_err_d;
  logic        busy_d;
  logic [4:0]  cnt_d;
  logic [7:0]  sts_d;

  always_comb begin
    lo_take   = (state == S_LO) && bus.ma_enable;
    hi_hit    = (state == S_HI) && bus.ma_enable &&
                (bus.ma_sel == sel_q);
    sel_miss  = (state == S_HI) && bus.ma_enable &&
                (bus.ma_sel != sel_q);
    pop       = !empty && bus.config_ready;
    // A pop in the same edge frees a slot for a push into a full FIFO.
    push      = hi_hit && (!full || pop);
    drop      = hi_hit && !push;
    ovf_d     = drop || (ovf && !bus.clr_status);
    sel_err_d = sel_miss || (sel_err && !bus.clr_status);
    busy_d    = lo_take || ((state == S_HI) && !hi_hit);
    cnt_d     = 5'(count) + 5'(push) - 5'(pop);
    sts_d     = {3'b000, cnt_d};
    sts_d[STS_OVF]    = ovf_d;
    sts_d[STS_SELERR] = sel_err_d;
    sts_d[STS_BUSY]   = busy_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LO;
      lo_q    <= '0;
      sel_q   <= '0;
      ovf     <= 1'b0;
      sel_err <= 1'b0;
      sts_q   <= rst_sl_send_data;
    end else begin
      ovf     <= ovf_d;
      sel_err <= sel_err_d;
      sts_q   <= sts_d;
      unique case (1'b1)
        lo_take, sel_miss: begin
          lo_q  <= bus.ma_send_data;
          sel_q <= bus.ma_sel;
          state <= S_HI;
        end
        hi_hit: begin
          state <= S_LO;
        end
        default: ;
      endcase
    end
  end

  ms_cfg_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ('{addr: sel_q,
              data: {bus.ma_send_data, lo_q}}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.config_valid = !empty;
  assign bus.config_addr  = head.addr;
  assign bus.config_data  = head.data;
  assign bus.sl_send_data = sts_q;

`ifdef MS_CFG_ERR_CNT_EN
  logic err_inc;
  assign err_inc = sel_miss || drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_inc) begin
      if (bus.clr_status) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (bus.clr_status) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule
